// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared encodings, state enum and constants for the fetch stage
package fetch_stage_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  // Encoding owned by decode; only mirrored here.
  typedef enum logic [1:0] {
    SEL_SEQ    = 2'b00,
    SEL_BRANCH = 2'b01,
    SEL_JAL    = 2'b10,
    SEL_JALR   = 2'b11
  } next_pc_sel_e;

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_WAIT  = 2'b01,
    S_DROP  = 2'b10,
    S_HOLD  = 2'b11
  } fetch_state_e;

  function automatic logic [31:0] align_target(input logic [31:0] t);
    return {t[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry holding register for a response that arrives while decode stalls
module fetch_skid_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [31:0] load_pc,
  input  logic        clear,
  output logic        valid,
  output logic [31:0] data,
  output logic [31:0] pc
);

  // Clear wins over load so a redirect always empties the entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      pc    <= load_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch with single outstanding request, redirect and decode backpressure
module fetch_stage #(
  parameter logic [31:0] RESET_PC = fetch_stage_pkg::DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  next_PC_sel,
  input  logic        redirect_valid,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] jal_target,
  input  logic [31:0] jalr_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [6:0]  if_opcode
);
  import fetch_stage_pkg::*;

  fetch_state_e state;
  logic [31:0]  pc;
  logic         redirect;
  logic [31:0]  raw_target;
  logic [31:0]  target;
  logic         skid_load;
  logic         skid_clear;
  logic         skid_valid;
  logic [31:0]  skid_data;
  logic [31:0]  skid_pc;

  always_comb begin
    redirect = redirect_valid &
               ((next_PC_sel == SEL_JAL) | (next_PC_sel == SEL_JALR) |
                ((next_PC_sel == SEL_BRANCH) & branch_taken));
    case (next_PC_sel)
      SEL_BRANCH: raw_target = branch_target;
      SEL_JAL:    raw_target = jal_target;
      SEL_JALR:   raw_target = jalr_target & ~32'd1;
      default:    raw_target = pc + 32'd4;
    endcase
    target = align_target(raw_target);
  end

  // No new request while the held instruction is still blocked by decode.
  assign imem_req  = (state == S_FETCH) & ~redirect & ~(if_valid & stall);
  assign imem_addr = pc;
  assign if_opcode = if_instr[6:0];

  assign skid_load  = (state == S_WAIT) & imem_rvalid & ~redirect & if_valid & stall;
  assign skid_clear = redirect | ((state == S_HOLD) & ~stall);

  fetch_skid_buf u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (skid_load),
    .load_data (imem_rdata),
    .load_pc   (pc),
    .clear     (skid_clear),
    .valid     (skid_valid),
    .data      (skid_data),
    .pc        (skid_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      if_pc    <= '0;
    end else if (redirect) begin
      pc       <= target;
      if_valid <= 1'b0;
      case (state)
        S_WAIT:  state <= imem_rvalid ? S_FETCH : S_DROP;
        S_DROP:  state <= imem_rvalid ? S_FETCH : S_DROP;
        default: state <= S_FETCH;
      endcase
    end else begin
      if (if_valid & ~stall) if_valid <= 1'b0;
      case (state)
        S_FETCH: begin
          if (imem_req) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            pc <= pc + 32'd4;
            if (~if_valid | ~stall) begin
              if_valid <= 1'b1;
              if_instr <= imem_rdata;
              if_pc    <= pc;
              state    <= S_FETCH;
            end else begin
              state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (~stall & skid_valid) begin
            if_valid <= 1'b1;
            if_instr <= skid_data;
            if_pc    <= skid_pc;
            state    <= S_FETCH;
          end
        end
        S_DROP: begin
          if (imem_rvalid) state <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
